// File: rtl/deco_pkg.sv
// Shared types for the decoder index sequencer.
package deco_pkg;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} scan_state_t;

    // Index width that still works for N=1 or N=2
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/deco_scan_ctrl_if.sv
// Control/status bundle between a scan controller and whoever starts it.
interface deco_scan_ctrl_if
    import deco_pkg::*;
#(
    parameter int N     = 20,
    parameter int DIV_W = 16
);
    localparam int IDX_W = idx_w(N);

    logic             start;
    logic             stop;
    logic             mode_cont;
    logic [DIV_W-1:0] div;
    logic [N-1:0]     mask;
    logic [IDX_W-1:0] idx;
    logic             en;
    logic             busy;
    logic             done;
    logic             wrap;

    modport master (output start, stop, mode_cont, div, mask,
                    input  idx, en, busy, done, wrap);
    modport slave  (input  start, stop, mode_cont, div, mask,
                    output idx, en, busy, done, wrap);
endinterface

// File: rtl/deco_scan_next_idx.sv
// Next enabled position after idx within mask, plus lowest enabled position.
// Combinational, zero latency; no flow control. Built only with SCAN_MASK_EN.
// Lowest set bit wins because the loop walks downward and overwrites.
`ifdef SCAN_MASK_EN
module deco_scan_next_idx #(
    parameter int N     = 20,
    parameter int IDX_W = 5
) (
    input  logic [IDX_W-1:0] idx,
    input  logic [N-1:0]     mask,
    output logic [IDX_W-1:0] nxt_idx,
    output logic             wrapped,
    output logic [IDX_W-1:0] first_idx
);
    always_comb begin
        nxt_idx   = '0;
        first_idx = '0;
        wrapped   = 1'b1;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i]) begin
                first_idx = IDX_W'(i);
                if (i > int'(idx)) begin
                    nxt_idx = IDX_W'(i);
                    wrapped = 1'b0;
                end
            end
        end
        if (wrapped) nxt_idx = first_idx;
    end
endmodule
`endif

// File: rtl/deco_scan_ctrl.sv
// Index sequencer for a 1-of-N decoder; SCAN_MASK_EN enables skipping masked positions.
// Latency: all outputs registered; first idx/en appear the cycle after an accepted start.
// Backpressure: none; the scan free-runs until the pass ends or stop aborts it.
module deco_scan_ctrl
    import deco_pkg::*;
#(
    parameter int N     = 20,
    parameter int DIV_W = 16
) (
    input logic            clk,
    input logic            rst_n,
    deco_scan_ctrl_if.slave bus
);
    localparam int IDX_W = idx_w(N);

    scan_state_t      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             en_q, en_d, busy_q, busy_d, done_q, done_d, wrap_q, wrap_d;
    logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d;
    logic             cont_q, cont_d;
    logic [IDX_W-1:0] nxt_idx, first_idx;
    logic             nxt_wrap, start_ok;

`ifdef SCAN_MASK_EN
    logic [N-1:0] mask_q, mask_d, mask_sel;

    // In IDLE the live mask feeds the walker so the first position is ready at start
    assign mask_sel = (state_q == IDLE) ? bus.mask : mask_q;
    assign start_ok = |bus.mask;

    deco_scan_next_idx #(.N(N), .IDX_W(IDX_W)) u_next (
        .idx      (idx_q),
        .mask     (mask_sel),
        .nxt_idx  (nxt_idx),
        .wrapped  (nxt_wrap),
        .first_idx(first_idx)
    );
`else
    logic unused_mask;

    assign unused_mask = ^bus.mask;
    assign start_ok    = 1'b1;
    assign first_idx   = '0;
    assign nxt_wrap    = (idx_q == IDX_W'(N - 1));
    assign nxt_idx     = nxt_wrap ? '0 : idx_q + IDX_W'(1);
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        en_d    = en_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        cnt_d   = cnt_q;
        div_d   = div_q;
        cont_d  = cont_q;
`ifdef SCAN_MASK_EN
        mask_d  = mask_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop && start_ok) begin
                    state_d = RUN;
                    idx_d   = first_idx;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = bus.div;
                    div_d   = bus.div;
                    cont_d  = bus.mode_cont;
`ifdef SCAN_MASK_EN
                    mask_d  = bus.mask;
`endif
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DIV_W'(1);
                end else if (nxt_wrap && !cont_q) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    wrap_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    idx_d  = nxt_idx;
                    wrap_d = nxt_wrap;
                    cnt_d  = div_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
            div_q   <= '0;
            cont_q  <= 1'b0;
`ifdef SCAN_MASK_EN
            mask_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            cont_q  <= cont_d;
`ifdef SCAN_MASK_EN
            mask_q  <= mask_d;
`endif
        end
    end

    assign bus.idx  = idx_q;
    assign bus.en   = en_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_deco_scan_ctrl.sv
// Bench for deco_scan_ctrl: vector table, directed corner sequences, random run vs position-list model.
module tb_deco_scan_ctrl;
    localparam int N     = 20;
    localparam int DIV_W = 16;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    deco_scan_ctrl_if #(.N(N), .DIV_W(DIV_W)) bus ();

    deco_scan_ctrl #(.N(N), .DIV_W(DIV_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: the scan is an ordered list of enabled positions
    int plist[$];
    int m_pos, m_left, m_div;
    bit m_busy, m_cont;
    int e_idx;
    bit e_en, e_done, e_wrap;

    task automatic model_reset();
        plist.delete();
        m_pos = 0; m_left = 0; m_div = 0;
        m_busy = 0; m_cont = 0;
        e_idx = 0; e_en = 0; e_done = 0; e_wrap = 0;
    endtask

    task automatic model_step();
        int cand[$];
        e_done = 0;
        e_wrap = 0;
        if (!rst_n) begin
            model_reset();
        end else if (!m_busy) begin
            for (int i = 0; i < N; i++) begin
`ifdef SCAN_MASK_EN
                if (bus.mask[i]) cand.push_back(i);
`else
                cand.push_back(i);
`endif
            end
            if (bus.start && !bus.stop && cand.size() > 0) begin
                plist  = cand;
                m_busy = 1; m_pos = 0;
                m_div  = int'(bus.div); m_left = m_div;
                m_cont = bus.mode_cont;
            end
        end else if (bus.stop) begin
            m_busy = 0;
        end else if (m_left > 0) begin
            m_left--;
        end else if (m_pos == plist.size() - 1) begin
            if (m_cont) begin
                m_pos = 0; m_left = m_div; e_wrap = 1;
            end else begin
                m_busy = 0; e_done = 1; e_wrap = 1;
            end
        end else begin
            m_pos++;
            m_left = m_div;
        end
        e_en  = m_busy;
        e_idx = m_busy ? plist[m_pos] : 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("model_idx",  32'(bus.idx),  32'(e_idx));
        chk("model_en",   32'(bus.en),   32'(e_en));
        chk("model_busy", 32'(bus.busy), 32'(e_en));
        chk("model_done", 32'(bus.done), 32'(e_done));
        chk("model_wrap", 32'(bus.wrap), 32'(e_wrap));
        chk("idx_range",  32'(int'(bus.idx) < N), 32'd1);
        chk("en_eq_busy", 32'(bus.en), 32'(bus.busy));
        chk("done_idle",  32'(bus.done && bus.busy), 32'd0);
    endtask

    // Inputs change only at the falling edge, so the model sees what the DUT sampled
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run_until_idx(input int target, input int limit);
        int n = 0;
        while (int'(bus.idx) != target && n < limit) begin
            step();
            n++;
        end
        chk("reach_idx", 32'(bus.idx), 32'(target));
    endtask

    typedef struct {
        logic             start, stop, cont;
        logic [DIV_W-1:0] div;
        int               idx;
        logic             en, busy, done, wrap;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{start:0, stop:0, cont:0, div:0, idx:0, en:0, busy:0, done:0, wrap:0};
        tbl[1]  = '{start:1, stop:1, cont:0, div:0, idx:0, en:0, busy:0, done:0, wrap:0};
        tbl[2]  = '{start:1, stop:0, cont:0, div:1, idx:0, en:1, busy:1, done:0, wrap:0};
        tbl[3]  = '{start:1, stop:0, cont:0, div:5, idx:0, en:1, busy:1, done:0, wrap:0};
        tbl[4]  = '{start:0, stop:0, cont:0, div:5, idx:1, en:1, busy:1, done:0, wrap:0};
        tbl[5]  = '{start:0, stop:0, cont:0, div:0, idx:1, en:1, busy:1, done:0, wrap:0};
        tbl[6]  = '{start:0, stop:0, cont:0, div:0, idx:2, en:1, busy:1, done:0, wrap:0};
        tbl[7]  = '{start:0, stop:1, cont:0, div:0, idx:0, en:0, busy:0, done:0, wrap:0};
        tbl[8]  = '{start:0, stop:0, cont:0, div:0, idx:0, en:0, busy:0, done:0, wrap:0};
        tbl[9]  = '{start:1, stop:0, cont:1, div:0, idx:0, en:1, busy:1, done:0, wrap:0};
        tbl[10] = '{start:0, stop:0, cont:1, div:0, idx:1, en:1, busy:1, done:0, wrap:0};
        tbl[11] = '{start:0, stop:1, cont:1, div:0, idx:0, en:0, busy:0, done:0, wrap:0};

        bus.start = 0; bus.stop = 0; bus.mode_cont = 0; bus.div = '0; bus.mask = '1;
        model_reset();
        rst_n = 0;
        #2;
        chk("rst_idx",  32'(bus.idx),  32'd0);
        chk("rst_en",   32'(bus.en),   32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_wrap", 32'(bus.wrap), 32'd0);
        step();
        rst_n = 1;
        step();

        // Vector table: start/stop priority, start ignored in RUN, stop abort
        for (int v = 0; v < 12; v++) begin
            bus.start = tbl[v].start; bus.stop = tbl[v].stop;
            bus.mode_cont = tbl[v].cont; bus.div = tbl[v].div;
            step();
            chk("tbl_idx",  32'(bus.idx),  32'(tbl[v].idx));
            chk("tbl_en",   32'(bus.en),   32'(tbl[v].en));
            chk("tbl_busy", 32'(bus.busy), 32'(tbl[v].busy));
            chk("tbl_done", 32'(bus.done), 32'(tbl[v].done));
            chk("tbl_wrap", 32'(bus.wrap), 32'(tbl[v].wrap));
        end
        bus.stop = 0;

        // Single pass, one cycle per position
        bus.start = 1; bus.div = 0; bus.mode_cont = 0;
        step();
        bus.start = 0;
        for (int i = 0; i < N; i++) begin
            if (i > 0) step();
            chk("pass_idx", 32'(bus.idx), 32'(i));
            chk("pass_en",  32'(bus.en),  32'd1);
        end
        step();
        chk("pass_end_en",   32'(bus.en),   32'd0);
        chk("pass_end_idx",  32'(bus.idx),  32'd0);
        chk("pass_end_done", 32'(bus.done), 32'd1);
        chk("pass_end_wrap", 32'(bus.wrap), 32'd1);
        step();
        chk("pass_done_pulse", 32'(bus.done), 32'd0);
        chk("pass_wrap_pulse", 32'(bus.wrap), 32'd0);

        // Continuous scan, dwell 4 cycles: wrap every 80 cycles
        bus.start = 1; bus.div = 3; bus.mode_cont = 1;
        for (int k = 1; k <= 170; k++) begin
            step();
            bus.start = 0;
            chk("cont_idx",  32'(bus.idx),  32'(((k - 1) % (4 * N)) / 4));
            chk("cont_wrap", 32'(bus.wrap), 32'(k > 1 && ((k - 1) % (4 * N)) == 0));
            chk("cont_en",   32'(bus.en),   32'd1);
        end
        bus.stop = 1; step(); bus.stop = 0;

        // Abort at idx 5
        bus.start = 1; bus.div = 0; bus.mode_cont = 0;
        step();
        bus.start = 0;
        run_until_idx(5, 30);
        bus.stop = 1;
        step();
        bus.stop = 0;
        chk("stop_en",   32'(bus.en),   32'd0);
        chk("stop_idx",  32'(bus.idx),  32'd0);
        chk("stop_busy", 32'(bus.busy), 32'd0);
        chk("stop_done", 32'(bus.done), 32'd0);
        chk("stop_wrap", 32'(bus.wrap), 32'd0);

        // Asynchronous reset mid-run at idx 7
        bus.start = 1; bus.div = 0; bus.mode_cont = 1;
        step();
        bus.start = 0;
        run_until_idx(7, 30);
        #2 rst_n = 0;
        #1;
        chk("arst_idx",  32'(bus.idx),  32'd0);
        chk("arst_en",   32'(bus.en),   32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        model_reset();
        step();
        step();
        rst_n = 1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("post_rst_busy", 32'(bus.busy), 32'd0);
        end

`ifdef SCAN_MASK_EN
        // Sparse mask: positions 2 and 5 only, two cycles each
        bus.mask = 20'h00024; bus.start = 1; bus.div = 1; bus.mode_cont = 0;
        step();
        bus.start = 0;
        chk("mask_idx_a", 32'(bus.idx), 32'd2);
        step(); chk("mask_idx_b", 32'(bus.idx), 32'd2);
        step(); chk("mask_idx_c", 32'(bus.idx), 32'd5);
        step(); chk("mask_idx_d", 32'(bus.idx), 32'd5);
        step();
        chk("mask_done", 32'(bus.done), 32'd1);
        chk("mask_en",   32'(bus.en),   32'd0);
        bus.mask = '0; bus.start = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("mask0_busy", 32'(bus.busy), 32'd0);
        end
        bus.start = 0; bus.mask = '1;
        step();
`endif

        // Random traffic against the model
        for (int k = 0; k < 1500; k++) begin
            bus.start     = ($urandom_range(0, 5) == 0);
            bus.stop      = ($urandom_range(0, 15) == 0);
            bus.mode_cont = 1'($urandom);
            bus.div       = DIV_W'($urandom_range(0, 3));
            bus.mask      = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
